// File: rtl/bus_sequencer_if.sv
// Memory-mapped bus between the sequencer (master) and memory (slave).
// The master issues read/write. The slave stretches an access by holding waitrequest.
interface bus_sequencer_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/bus_sequencer.sv
// Multi-cycle fetch/execute bus sequencer: FETCH -> EXEC1 (optional load/store) -> EXEC2.
// Bus requests are built combinationally and frozen while the slave stretches an access.
module bus_sequencer (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            pc,
    input  logic [31:0]            data_addr,
    input  logic                   is_load,
    input  logic                   is_store,
    input  logic                   reg_write_req,
    input  logic                   halt,
    input  logic [31:0]            store_data,
    input  logic [3:0]             byteenable_in,
    bus_sequencer_if.master        bus,
    output logic [31:0]            instr,
    output logic [31:0]            load_data,
    output logic [1:0]             state,
    output logic                   stall,
    output logic                   pc_update,
    output logic                   reg_write_en,
    output logic                   active,
    output logic [31:0]            cycle_count
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        HALT  = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] instr_q;
    logic [31:0] load_data_q;
    logic [31:0] cycle_count_q;

    // Snapshot of a stalled request so the bus stays frozen even if the
    // upstream pc/data inputs move during the wait.
    logic        pend_q;
    logic        hold_rd_q;
    logic        hold_wr_q;
    logic [31:0] hold_addr_q;
    logic [31:0] hold_wdata_q;
    logic [3:0]  hold_be_q;

    logic        acc_rd_d;
    logic        acc_wr_d;
    logic [31:0] acc_addr_d;
    logic [31:0] acc_wdata_d;
    logic [3:0]  acc_be_d;
    logic        stall_d;

    always_comb begin
        acc_rd_d    = 1'b0;
        acc_wr_d    = 1'b0;
        acc_addr_d  = 32'd0;
        acc_wdata_d = 32'd0;
        acc_be_d    = 4'd0;
        if (pend_q) begin
            acc_rd_d    = hold_rd_q;
            acc_wr_d    = hold_wr_q;
            acc_addr_d  = hold_addr_q;
            acc_wdata_d = hold_wdata_q;
            acc_be_d    = hold_be_q;
        end else begin
            case (state_q)
                FETCH: begin
                    acc_rd_d   = 1'b1;
                    acc_addr_d = pc;
                    acc_be_d   = 4'hF;
                end
                EXEC1: begin
                    // Load wins when both are requested.
                    if (is_load || is_store) begin
                        acc_rd_d    = is_load;
                        acc_wr_d    = ~is_load;
                        acc_addr_d  = {data_addr[31:2], 2'b00};
                        acc_be_d    = byteenable_in;
                        acc_wdata_d = is_load ? 32'd0 : store_data;
                    end
                end
                default: ;
            endcase
        end
        if (rst) begin
            acc_rd_d = 1'b0;
            acc_wr_d = 1'b0;
        end
        stall_d = (acc_rd_d || acc_wr_d) && bus.waitrequest;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            instr_q       <= 32'd0;
            load_data_q   <= 32'd0;
            cycle_count_q <= 32'd0;
            pend_q        <= 1'b0;
            hold_rd_q     <= 1'b0;
            hold_wr_q     <= 1'b0;
            hold_addr_q   <= 32'd0;
            hold_wdata_q  <= 32'd0;
            hold_be_q     <= 4'd0;
        end else begin
            if (state_q != HALT)
                cycle_count_q <= cycle_count_q + 32'd1;
            pend_q       <= stall_d;
            hold_rd_q    <= acc_rd_d;
            hold_wr_q    <= acc_wr_d;
            hold_addr_q  <= acc_addr_d;
            hold_wdata_q <= acc_wdata_d;
            hold_be_q    <= acc_be_d;
            case (state_q)
                FETCH: begin
                    if (!bus.waitrequest) begin
                        instr_q <= bus.readdata;
                        state_q <= EXEC1;
                    end
                end
                EXEC1: begin
                    if (acc_rd_d) begin
                        if (!bus.waitrequest) begin
                            load_data_q <= bus.readdata;
                            state_q     <= EXEC2;
                        end
                    end else if (acc_wr_d) begin
                        if (!bus.waitrequest)
                            state_q <= EXEC2;
                    end else begin
                        state_q <= EXEC2;
                    end
                end
                EXEC2:   state_q <= halt ? HALT : FETCH;
                default: state_q <= HALT;
            endcase
        end
    end

    assign bus.read       = acc_rd_d;
    assign bus.write      = acc_wr_d;
    assign bus.address    = acc_addr_d;
    assign bus.writedata  = acc_wdata_d;
    assign bus.byteenable = acc_be_d;

    assign stall        = stall_d;
    assign pc_update    = (state_q == EXEC2) && !rst;
    assign reg_write_en = (state_q == EXEC2) && reg_write_req && !rst;
    assign active       = (state_q != HALT);
    assign state        = state_q;
    assign instr        = instr_q;
    assign load_data    = load_data_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: pc  in  32  instruction fetch address; data_addr  in  32  load/store byte address.
REQ-004 SHALL have: is_load  in  1; is_store  in  1; reg_write_req  in  1; halt  in  1.
REQ-005 SHALL have: store_data  in  32; byteenable_in  in  4  data-access lane enables.
REQ-006 SHALL have bus master ports: address  out  32; read  out  1; write  out  1; writedata  out  32; byteenable  out  4; waitrequest  in  1; readdata  in  32.
REQ-007 SHALL have: instr  out  32  latched instruction; load_data  out  32  latched load word.
REQ-008 SHALL have: state  out  2  (0 FETCH, 1 EXEC1, 2 EXEC2, 3 HALT); stall  out  1; pc_update  out  1; reg_write_en  out  1; active  out  1; cycle_count  out  32.

Function
REQ-009 SHALL implement the FSM FETCH -> EXEC1 -> EXEC2 -> FETCH, with EXEC2 -> HALT when halt=1.
REQ-010 FETCH SHALL drive read=1, address=pc, byteenable=4'hF, write=0.
REQ-011 FETCH SHALL remain in FETCH while waitrequest=1; on the first cycle with waitrequest=0, instr SHALL load readdata and state SHALL become EXEC1.
REQ-012 EXEC1 with is_load=1 SHALL drive read=1, address={data_addr[31:2],2'b00}, byteenable=byteenable_in; on accept (waitrequest=0), load_data SHALL load readdata and state SHALL become EXEC2.
REQ-013 EXEC1 with is_store=1 and is_load=0 SHALL drive write=1, same address/byteenable, writedata=store_data; on accept, state SHALL become EXEC2.
REQ-014 EXEC1 with is_load=1 and is_store=1 SHALL behave as a load (load priority).
REQ-015 EXEC1 with neither is_load nor is_store SHALL issue no bus access and advance to EXEC2 after exactly one cycle.
REQ-016 address, read, write, writedata and byteenable SHALL be held stable while waitrequest=1.
REQ-017 read and write SHALL never be high in the same cycle; both SHALL be 0 in EXEC2 and HALT.
REQ-018 stall SHALL be 1 exactly in cycles where read or write is 1 and waitrequest=1.
REQ-019 In EXEC2, pc_update SHALL be 1 for exactly that one cycle, and reg_write_en SHALL equal reg_write_req; both SHALL be 0 in all other states.
REQ-020 EXEC2 SHALL sample halt: halt=1 -> HALT, else FETCH.
REQ-021 HALT SHALL persist until rst; active SHALL be 0 in HALT and 1 in every other state.
REQ-022 cycle_count SHALL increment by 1 each cycle while active=1, wrap 0xFFFFFFFF -> 0, and hold in HALT.
REQ-023 Latency SHALL be 3 cycles per instruction with zero wait states, plus one cycle per waitrequest=1 cycle in FETCH or in an EXEC1 access.
REQ-024 waitrequest SHALL be ignored in EXEC2, HALT, and in EXEC1 when no access is issued.

Reset
REQ-025 When rst=1 at a rising edge: state=FETCH, instr=0, load_data=0, cycle_count=0, active=1.
REQ-026 While rst=1, read, write, pc_update, reg_write_en and stall SHALL be forced to 0.
REQ-027 rst asserted mid-access (including during waitrequest=1) SHALL abort the access without latching readdata, and a fresh FETCH SHALL start on the first cycle after rst falls.

Verification
REQ-028 Reset; pc=0xBFC00000; waitrequest=0; readdata=0x24020005; no load/store -> cycle 1: read=1, address=0xBFC00000; cycle 2: EXEC1 with instr=0x24020005; cycle 3: pc_update=1; cycle 4: FETCH.
REQ-029 FETCH with waitrequest=1 for 2 cycles -> stall=1 for 2 cycles, address held; EXEC1 reached on cycle 4.
REQ-030 Load with data_addr=0x00001003, byteenable_in=4'b1000, readdata=0xDEADBEEF -> address=0x00001000, byteenable=4'b1000, load_data=0xDEADBEEF in EXEC2.
REQ-031 Store with store_data=0x0000ABCD, byteenable_in=4'b0011, waitrequest=1 for 1 cycle -> write=1 for 2 cycles, writedata stable, read=0, stall=1 for 1 cycle.
REQ-032 halt=1 in EXEC2 -> HALT, active=0, no read/write, cycle_count frozen; rst pulse -> FETCH, cycle_count=0.
REQ-033 rst=1 during an EXEC1 load with waitrequest=1 -> read=0 in the reset cycle, load_data=0, FETCH with read=1 on the first cycle after rst falls.
